// File: rtl/mrt_write_sequencer.sv
// Serialises one accepted MRT fragment bundle into one memory write per effective render target.
// Latency: accept at edge N presents the first write in cycle N+1; k effective RTs take k+1 cycles.
// Backpressure: mem_* held stable while mem_valid && !mem_ready; frag_ready low until the last write.
//
// Ports:
//   clk, rstn                       clock, asynchronous active-low reset
//   cfg_rt_enable/base/pitch        per-RT enable and surface geometry (RT i at slice i), sampled at accept
//   frag_valid/ready, x, y, mask,   fragment bundle handshake and contents
//   frag_data
//   mem_valid/ready, addr, data, rt write request to the ROP memory port (owned exclusively)
//   idle                            no fragment held
//   drop_cnt                        saturating count of fragments with zero effective mask
module mrt_write_sequencer #(
  parameter int NUM_RT      = 4,
  parameter int DATA_WIDTH  = 128,
  parameter int ADDR_WIDTH  = 32,
  parameter int XY_WIDTH    = 12,
  parameter int PITCH_WIDTH = 16
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic [NUM_RT-1:0]                 cfg_rt_enable,
  input  logic [NUM_RT*ADDR_WIDTH-1:0]      cfg_base,
  input  logic [NUM_RT*PITCH_WIDTH-1:0]     cfg_pitch,
  input  logic                              frag_valid,
  output logic                              frag_ready,
  input  logic [XY_WIDTH-1:0]               frag_x,
  input  logic [XY_WIDTH-1:0]               frag_y,
  input  logic [NUM_RT-1:0]                 frag_mask,
  input  logic [NUM_RT*DATA_WIDTH-1:0]      frag_data,
  output logic                              mem_valid,
  input  logic                              mem_ready,
  output logic [ADDR_WIDTH-1:0]             mem_addr,
  output logic [DATA_WIDTH-1:0]             mem_data,
  output logic [$clog2(NUM_RT)-1:0]         mem_rt,
  output logic                              idle,
  output logic [15:0]                       drop_cnt
);

  localparam int RT_W = $clog2(NUM_RT);
  localparam int BPP  = DATA_WIDTH / 8;
  localparam int PW   = XY_WIDTH + PITCH_WIDTH;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_ISSUE = 1'b1
  } state_t;

  state_t                state, state_nxt;
  logic [NUM_RT-1:0]     pending;
  logic [NUM_RT-1:0]     pending_clr;
  logic [NUM_RT-1:0]     eff_mask;
  logic [RT_W-1:0]       cur;
  logic                  accept;
  logic                  mem_fire;
  logic [PW-1:0]         row_off   [NUM_RT];
  logic [ADDR_WIDTH-1:0] addr_calc [NUM_RT];
  logic [ADDR_WIDTH-1:0] addr_q    [NUM_RT];
  logic [DATA_WIDTH-1:0] data_q    [NUM_RT];

  assign eff_mask = frag_mask & cfg_rt_enable;
  assign accept   = frag_valid && frag_ready;
  assign mem_fire = mem_valid && mem_ready;

  // Lowest set bit of pending selects the current write; scanning downward
  // leaves the lowest index as the final assignment.
  always_comb begin
    cur = '0;
    for (int i = NUM_RT - 1; i >= 0; i--) begin
      if (pending[i]) cur = RT_W'(i);
    end
  end

  assign pending_clr = pending & ~(NUM_RT'(1) << cur);

  // Surface addresses wrap modulo 2^ADDR_WIDTH; the row product is kept at
  // full XY+PITCH width before truncation into the sum.
  always_comb begin
    for (int i = 0; i < NUM_RT; i++) begin
      row_off[i]   = PW'(frag_y) * PW'(cfg_pitch[i*PITCH_WIDTH +: PITCH_WIDTH]);
      addr_calc[i] = cfg_base[i*ADDR_WIDTH +: ADDR_WIDTH]
                   + ADDR_WIDTH'(row_off[i])
                   + ADDR_WIDTH'(frag_x) * ADDR_WIDTH'(BPP);
    end
  end

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept && (eff_mask != '0))        state_nxt = S_ISSUE;
      S_ISSUE: if (mem_fire && (pending_clr == '0))   state_nxt = S_IDLE;
      default:                                        state_nxt = S_IDLE;
    endcase
  end

  // Outputs decode registered state only; mem_* mux is driven by pending and
  // the latched arrays, so reset (pending=0, arrays=0) yields zero outputs.
  always_comb begin
    frag_ready = (state == S_IDLE);
    mem_valid  = (state == S_ISSUE);
    idle       = (state == S_IDLE);
    mem_rt     = cur;
    mem_addr   = addr_q[cur];
    mem_data   = data_q[cur];
  end

  // Fragment hold registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pending <= '0;
      for (int i = 0; i < NUM_RT; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else if (accept) begin
      pending <= eff_mask;
      for (int i = 0; i < NUM_RT; i++) begin
        addr_q[i] <= addr_calc[i];
        data_q[i] <= frag_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end else if (mem_fire) begin
      pending <= pending_clr;
    end
  end

  // Drop counter saturates at all-ones
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      drop_cnt <= '0;
    end else if (accept && (eff_mask == '0) && (drop_cnt != 16'hFFFF)) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_mrt_write_sequencer.sv
module tb_mrt_write_sequencer;

  localparam int NRT = 4;
  localparam int DW  = 128;
  localparam int AW  = 32;
  localparam int XYW = 12;
  localparam int PTW = 16;

  logic              clk = 1'b0;
  logic              rstn;
  logic [NRT-1:0]    cfg_rt_enable;
  logic [NRT*AW-1:0] cfg_base;
  logic [NRT*PTW-1:0] cfg_pitch;
  logic              frag_valid;
  logic              frag_ready;
  logic [XYW-1:0]    frag_x, frag_y;
  logic [NRT-1:0]    frag_mask;
  logic [NRT*DW-1:0] frag_data;
  logic              mem_valid;
  logic              mem_ready;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_data;
  logic [1:0]        mem_rt;
  logic              idle;
  logic [15:0]       drop_cnt;

  mrt_write_sequencer #(
    .NUM_RT(NRT), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .XY_WIDTH(XYW), .PITCH_WIDTH(PTW)
  ) dut (
    .clk(clk), .rstn(rstn),
    .cfg_rt_enable(cfg_rt_enable), .cfg_base(cfg_base), .cfg_pitch(cfg_pitch),
    .frag_valid(frag_valid), .frag_ready(frag_ready),
    .frag_x(frag_x), .frag_y(frag_y), .frag_mask(frag_mask), .frag_data(frag_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_data(mem_data), .mem_rt(mem_rt), .idle(idle), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: list of writes still owed for the held fragment
  typedef struct {
    logic [1:0]    rt;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t         exp_q[$];
  int          drop_m;
  int          errors = 0;
  int          checks = 0;
  logic [1:0]  hs_rt[$];
  logic [AW-1:0] hs_addr[$];

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("mem_valid", mem_valid, exp_q.size() != 0);
    chk("frag_ready", frag_ready, exp_q.size() == 0);
    chk("idle", idle, exp_q.size() == 0);
    chk("drop_cnt", drop_cnt, drop_m[15:0]);
    if (exp_q.size() != 0) begin
      chk("mem_rt", mem_rt, exp_q[0].rt);
      chk("mem_addr", mem_addr, exp_q[0].addr);
      chk("mem_data", mem_data, exp_q[0].data);
    end
  endtask

  // Advance the model across the coming edge using the inputs now driven.
  task automatic model_edge();
    if (exp_q.size() != 0) begin
      if (mem_ready) begin
        hs_rt.push_back(mem_rt);
        hs_addr.push_back(mem_addr);
        void'(exp_q.pop_front());
      end
    end else if (frag_valid) begin
      for (int i = 0; i < NRT; i++) begin
        if (frag_mask[i] && cfg_rt_enable[i]) begin
          longint unsigned a;
          wr_t w;
          a = longint'(cfg_base[i*AW +: AW]) + longint'(frag_y) * longint'(cfg_pitch[i*PTW +: PTW])
            + longint'(frag_x) * (DW / 8);
          w.rt   = 2'(i);
          w.addr = a[AW-1:0];
          w.data = frag_data[i*DW +: DW];
          exp_q.push_back(w);
        end
      end
      if (exp_q.size() == 0) drop_m = (drop_m >= 65535) ? 65535 : drop_m + 1;
    end
  endtask

  task automatic cycle();
    check_outputs();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_data();
    for (int w = 0; w < NRT * DW / 32; w++) frag_data[w*32 +: 32] = $urandom();
  endtask

  task automatic set_frag(input logic [NRT-1:0] m, input int x, input int y);
    frag_valid = 1'b1;
    frag_mask  = m;
    frag_x     = XYW'(x);
    frag_y     = XYW'(y);
    rand_data();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rstn = 1'b0;
    cfg_rt_enable = '1; cfg_base = '0; cfg_pitch = '0;
    frag_valid = 1'b0; frag_x = '0; frag_y = '0; frag_mask = '0; frag_data = '0;
    mem_ready = 1'b0;
    drop_m = 0;
    #1;
    chk("rst_mem_valid", mem_valid, 1'b0);
    chk("rst_idle", idle, 1'b1);
    chk("rst_frag_ready", frag_ready, 1'b1);
    chk("rst_mem_addr", mem_addr, '0);
    chk("rst_mem_data", mem_data, '0);
    chk("rst_mem_rt", mem_rt, '0);
    chk("rst_drop_cnt", drop_cnt, '0);
    @(posedge clk); #1;
    rstn = 1'b1;

    // Basic issue
    cfg_rt_enable = 4'b1111;
    for (int i = 0; i < NRT; i++) begin
      cfg_base[i*AW +: AW]   = 32'h1000_0000 * (i + 1);
      cfg_pitch[i*PTW +: PTW] = 16'h1000;
    end
    mem_ready = 1'b1;
    hs_rt.delete(); hs_addr.delete();
    set_frag(4'b1011, 2, 3);
    cycle();
    frag_valid = 1'b0;
    repeat (4) cycle();
    chk("basic_nwr", hs_rt.size(), 3);
    if (hs_rt.size() == 3) begin
      chk("basic_rt0", hs_rt[0], 2'd0);
      chk("basic_rt1", hs_rt[1], 2'd1);
      chk("basic_rt2", hs_rt[2], 2'd3);
      chk("basic_a0", hs_addr[0], 32'h1000_3020);
      chk("basic_a1", hs_addr[1], 32'h2000_3020);
      chk("basic_a2", hs_addr[2], 32'h4000_3020);
    end

    // Enable gating, base changed right after accept
    hs_rt.delete(); hs_addr.delete();
    cfg_rt_enable = 4'b0101;
    set_frag(4'b1111, 7, 5);
    cycle();
    frag_valid = 1'b0;
    cfg_base = {4{32'hDEAD_0000}};
    repeat (3) cycle();
    chk("gate_nwr", hs_rt.size(), 2);
    if (hs_rt.size() == 2) begin
      chk("gate_rt0", hs_rt[0], 2'd0);
      chk("gate_rt1", hs_rt[1], 2'd2);
    end

    // Backpressure on the RT1 write
    cfg_rt_enable = 4'b1111;
    set_frag(4'b1111, 100, 200);
    cycle();
    frag_valid = 1'b0;
    cycle();                      // RT0 handshake
    mem_ready = 1'b0;
    repeat (3) cycle();           // RT1 stalled, outputs held by model check
    mem_ready = 1'b1;
    repeat (4) cycle();

    // Three back-to-back drops
    set_frag(4'b0000, 1, 1);
    repeat (3) cycle();
    frag_valid = 1'b0;
    cycle();
    chk("drop3", drop_cnt, 16'd3);

    // Address wrap
    cfg_base[0 +: AW] = 32'hFFFF_FFF0;
    set_frag(4'b0001, 1, 0);
    cycle();
    frag_valid = 1'b0;
    chk("wrap_addr", mem_addr, 32'h0000_0000);
    cycle();
    cycle();

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      mem_ready     = ($urandom_range(0, 3) != 0);
      cfg_rt_enable = NRT'($urandom());
      if ($urandom_range(0, 7) == 0) begin
        for (int i = 0; i < NRT; i++) begin
          cfg_base[i*AW +: AW]    = $urandom();
          cfg_pitch[i*PTW +: PTW] = PTW'($urandom());
        end
      end
      if ($urandom_range(0, 1) == 1) set_frag(NRT'($urandom()), $urandom_range(0, 4095), $urandom_range(0, 4095));
      else frag_valid = 1'b0;
      cycle();
    end
    frag_valid = 1'b0;
    mem_ready  = 1'b1;
    repeat (6) cycle();

    // Async reset while the second of four writes is stalled
    cfg_rt_enable = 4'b1111;
    mem_ready = 1'b0;
    set_frag(4'b1111, 3, 3);
    cycle();
    frag_valid = 1'b0;
    mem_ready  = 1'b1;
    cycle();                      // RT0 handshake
    mem_ready  = 1'b0;
    cycle();
    chk("prerst_rt", mem_rt, 2'd1);
    chk("prerst_valid", mem_valid, 1'b1);
    rstn = 1'b0;
    #1;
    chk("arst_mem_valid", mem_valid, 1'b0);
    chk("arst_idle", idle, 1'b1);
    exp_q.delete();
    drop_m = 0;
    @(posedge clk); #2;
    rstn = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b1;
    hs_rt.delete(); hs_addr.delete();
    set_frag(4'b1110, 9, 9);
    cycle();
    frag_valid = 1'b0;
    repeat (4) cycle();
    chk("post_rst_nwr", hs_rt.size(), 3);
    if (hs_rt.size() == 3) chk("post_rst_first", hs_rt[0], 2'd1);

    // Drop counter saturation
    set_frag(4'b0000, 0, 0);
    repeat (65536) @(posedge clk);
    #1;
    drop_m = (drop_m + 65536 > 65535) ? 65535 : drop_m + 65536;
    chk("sat_model", drop_cnt, drop_m[15:0]);
    chk("sat_ffff", drop_cnt, 16'hFFFF);
    cycle();
    frag_valid = 1'b0;
    cycle();
    chk("sat_hold", drop_cnt, 16'hFFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
